// File: rtl/mask_expander_pkg.sv
// Shared constants, FSM state type and popcount helper for the mask expander.
package mask_expander_pkg;

  localparam int unsigned LANES = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {IDLE, FILL, OUT} state_e;

  function automatic logic [CNT_W-1:0] popcount32(input logic [LANES-1:0] vec);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      cnt = cnt + CNT_W'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lsb_onehot32.sv
// Combinational lowest-set-bit finder: one-hot select plus binary index (0 when vec_i is 0).
module lsb_onehot32 (
  input  logic [31:0] vec_i,
  output logic [31:0] onehot_o,
  output logic [4:0]  idx_o
);

  always_comb begin
    onehot_o = vec_i & (~vec_i + 32'd1);
    idx_o    = '0;
    // Scan high to low so the lowest set bit is the last (winning) assignment.
    for (int i = 31; i >= 0; i--) begin
      if (vec_i[i]) idx_o = 5'(i);
    end
  end

endmodule

// File: rtl/mask_expander.sv
// Expands a stream of compacted elements into a 32-lane vector under a lane-occupancy mask.
// Optional out_count port (popcount of out_mask) is enabled by MASK_EXPANDER_COUNT_EN.
module mask_expander #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          mask_valid,
  output logic                          mask_ready,
  input  logic [LANES-1:0]              mask_data,
  input  logic                          elem_valid,
  output logic                          elem_ready,
  input  logic [DATA_WIDTH-1:0]         elem_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic [LANES-1:0]              out_mask
`ifdef MASK_EXPANDER_COUNT_EN
  ,
  output logic [mask_expander_pkg::CNT_W-1:0] out_count
`endif
);

  import mask_expander_pkg::*;

  state_e                      state_q, state_d;
  logic [LANES*DATA_WIDTH-1:0] buf_q, buf_d;
  logic [LANES-1:0]            mask_q, mask_d;
  logic [LANES-1:0]            rem_q, rem_d;
  logic [LANES-1:0]            lsb_onehot;
  logic [4:0]                  lsb_idx;
  logic                        mask_fire, elem_fire, last_elem;

  lsb_onehot32 u_lsb (
    .vec_i    (rem_q),
    .onehot_o (lsb_onehot),
    .idx_o    (lsb_idx)
  );

  assign mask_fire = mask_valid & mask_ready;
  assign elem_fire = elem_valid & elem_ready;
  assign last_elem = (rem_q & ~lsb_onehot) == '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mask_valid) state_d = (mask_data == '0) ? OUT : FILL;
      FILL:    if (elem_valid && last_elem) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mask_ready = (state_q == IDLE);
    elem_ready = (state_q == FILL);
    out_valid  = (state_q == OUT);
  end

  // Only lanes selected by rem are ever written, so unmasked lanes stay at the cleared zero.
  always_comb begin
    buf_d  = buf_q;
    mask_d = mask_q;
    rem_d  = rem_q;
    if (mask_fire) begin
      buf_d  = '0;
      mask_d = mask_data;
      rem_d  = mask_data;
    end else if (elem_fire) begin
      buf_d[lsb_idx*DATA_WIDTH +: DATA_WIDTH] = elem_data;
      rem_d = rem_q & ~lsb_onehot;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q  <= '0;
      mask_q <= '0;
      rem_q  <= '0;
    end else begin
      buf_q  <= buf_d;
      mask_q <= mask_d;
      rem_q  <= rem_d;
    end
  end

  assign out_data = buf_q;
  assign out_mask = mask_q;

`ifdef MASK_EXPANDER_COUNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       count_q <= '0;
    else if (mask_fire) count_q <= popcount32(mask_data);
  end

  assign out_count = count_q;
`endif

endmodule

// File: tb/tb_mask_expander.sv
// Scoreboard bench for mask_expander: expected vectors queued at stimulus time, popped at output.
module tb_mask_expander;

  localparam int DW = 8;
  localparam int NL = 32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             mask_valid = 1'b0;
  logic             mask_ready;
  logic [NL-1:0]    mask_data = '0;
  logic             elem_valid = 1'b0;
  logic             elem_ready;
  logic [DW-1:0]    elem_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [NL*DW-1:0] out_data;
  logic [NL-1:0]    out_mask;
`ifdef MASK_EXPANDER_COUNT_EN
  logic [5:0]       out_count;
`endif

  typedef struct packed {
    logic [NL*DW-1:0] data;
    logic [NL-1:0]    mask;
    logic [5:0]       count;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mask_expander #(.DATA_WIDTH(DW), .LANES(NL)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mask_valid (mask_valid),
    .mask_ready (mask_ready),
    .mask_data  (mask_data),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .elem_data  (elem_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_mask   (out_mask)
`ifdef MASK_EXPANDER_COUNT_EN
    ,
    .out_count  (out_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference: walk lanes in ascending order, handing out elements in arrival order.
  function automatic exp_t model(input logic [NL-1:0] m, input logic [DW-1:0] el [NL]);
    exp_t e;
    int   n;
    e      = '0;
    n      = 0;
    e.mask = m;
    for (int i = 0; i < NL; i++) begin
      if (m[i]) begin
        e.data[i*DW +: DW] = el[n];
        n++;
        e.count = e.count + 6'd1;
      end
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_mask(input logic [NL-1:0] m, input string name);
    bit done;
    done       = 1'b0;
    mask_valid = 1'b1;
    mask_data  = m;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (mask_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    mask_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_mask_accept: mask_ready never seen, required acceptance within 40 cycles",
               name);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    @(negedge clk);
    checks++;
    if ({mask_ready, elem_ready, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_handshake: got %b required 100", {mask_ready, elem_ready, out_valid});
    end
    checks++;
    if (out_data !== '0 || out_mask !== '0) begin
      errors++;
      $display("FAIL reset_data: got data %h mask %h required zeros", out_data, out_mask);
    end
`ifdef MASK_EXPANDER_COUNT_EN
    checks++;
    if (out_count !== 6'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d required 0", out_count);
    end
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] el [NL];
    exp_t e;
    for (int i = 0; i < NL; i++) el[i] = '0;
    el[0] = 8'hAA;
    el[1] = 8'hBB;
    exp_q.push_back(model(32'h0000_0005, el));
    accept_mask(32'h0000_0005, "basic");
    elem_valid = 1'b1;
    elem_data  = 8'hAA;
    @(negedge clk);
    checks++;
    if (elem_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_fill: got elem_ready %b out_valid %b required 1 0", elem_ready, out_valid);
    end
    step();
    elem_data = 8'hBB;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_out: got out_valid %b required 0", out_valid);
    end
    step();
    elem_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: got out_valid %b required 1 at cycle 3", out_valid);
    end
    checks++;
    if (out_data !== e.data || out_mask !== e.mask) begin
      errors++;
      $display("FAIL basic_data: got %h/%h required %h/%h", out_data, out_mask, e.data, e.mask);
    end
    release_out();
  endtask

  task automatic test_zero();
    logic [DW-1:0] el [NL];
    exp_t e;
    for (int i = 0; i < NL; i++) el[i] = '0;
    exp_q.push_back(model(32'h0, el));
    accept_mask(32'h0, "zero");
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_latency: got out_valid %b required 1", out_valid);
    end
    checks++;
    if (out_data !== e.data || out_mask !== e.mask) begin
      errors++;
      $display("FAIL zero_data: got %h/%h required %h/%h", out_data, out_mask, e.data, e.mask);
    end
`ifdef MASK_EXPANDER_COUNT_EN
    checks++;
    if (out_count !== e.count) begin
      errors++;
      $display("FAIL zero_count: got %0d required %0d", out_count, e.count);
    end
`endif
    release_out();
  endtask

  task automatic test_full();
    logic [DW-1:0] el [NL];
    exp_t e;
    for (int i = 0; i < NL; i++) el[i] = DW'(i);
    exp_q.push_back(model(32'hFFFF_FFFF, el));
    accept_mask(32'hFFFF_FFFF, "full");
    for (int i = 0; i < NL; i++) begin
      elem_valid = 1'b1;
      elem_data  = DW'(i);
      if (i == NL - 1) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL full_early_out: got out_valid %b required 0 before last elem", out_valid);
        end
      end
      step();
      elem_valid = 1'b0;
      if (i < NL - 1) step();
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_out_valid: got %b required 1", out_valid);
    end
    checks++;
    if (out_data !== e.data || out_mask !== e.mask) begin
      errors++;
      $display("FAIL full_data: got %h/%h required %h/%h", out_data, out_mask, e.data, e.mask);
    end
`ifdef MASK_EXPANDER_COUNT_EN
    checks++;
    if (out_count !== 6'd32) begin
      errors++;
      $display("FAIL full_count: got %0d required 32", out_count);
    end
`endif
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] el [NL];
    exp_t e;
    for (int i = 0; i < NL; i++) el[i] = '0;
    el[0] = 8'h5A;
    exp_q.push_back(model(32'h0000_0010, el));
    accept_mask(32'h0000_0010, "stall");
    elem_valid = 1'b1;
    elem_data  = 8'h5A;
    step();
    elem_valid = 1'b0;
    mask_valid = 1'b1;
    mask_data  = 32'h0000_0003;
    e = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || mask_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hs_%0d: got out_valid %b mask_ready %b required 1 0",
                 c, out_valid, mask_ready);
      end
      checks++;
      if (out_data !== e.data || out_mask !== e.mask) begin
        errors++;
        $display("FAIL stall_data_%0d: got %h/%h required %h/%h",
                 c, out_data, out_mask, e.data, e.mask);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (mask_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got mask_ready %b out_valid %b required 1 0",
               mask_ready, out_valid);
    end
    step();
    mask_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (elem_ready !== 1'b1 || mask_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_next_accept: got elem_ready %b mask_ready %b required 1 0",
               elem_ready, mask_ready);
    end
    el[0] = 8'h01;
    el[1] = 8'h02;
    exp_q.push_back(model(32'h0000_0003, el));
    elem_valid = 1'b1;
    elem_data  = 8'h01;
    step();
    elem_data = 8'h02;
    step();
    elem_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== e.data || out_mask !== e.mask) begin
      errors++;
      $display("FAIL b2b_data: got %b %h/%h required 1 %h/%h",
               out_valid, out_data, out_mask, e.data, e.mask);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] el [NL];
    exp_t e;
    bit   seen;
    for (int i = 0; i < NL; i++) el[i] = '0;
    accept_mask(32'h8000_0001, "rstmid");
    elem_valid = 1'b1;
    elem_data  = 8'h77;
    step();
    elem_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mask_ready, elem_ready, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL rstmid_handshake: got %b required 100", {mask_ready, elem_ready, out_valid});
    end
    checks++;
    if (out_data !== '0 || out_mask !== '0) begin
      errors++;
      $display("FAIL rstmid_data: got %h/%h required zeros", out_data, out_mask);
    end
    step();
    step();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rstmid_stale: got out_valid after reset, required none");
    end
    @(posedge clk);
    #1;
    el[0] = 8'h11;
    exp_q.push_back(model(32'h0000_0002, el));
    accept_mask(32'h0000_0002, "rstmid");
    elem_valid = 1'b1;
    elem_data  = 8'h11;
    step();
    elem_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== e.data || out_mask !== e.mask) begin
      errors++;
      $display("FAIL rstmid_after: got %b %h/%h required 1 %h/%h",
               out_valid, out_data, out_mask, e.data, e.mask);
    end
    release_out();
  endtask

  task automatic test_elem_in_idle();
    logic [DW-1:0] el [NL];
    exp_t e;
    for (int i = 0; i < NL; i++) el[i] = '0;
    elem_valid = 1'b1;
    elem_data  = 8'h3C;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (elem_ready !== 1'b0 || mask_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_elem_%0d: got elem_ready %b mask_ready %b required 0 1",
                 c, elem_ready, mask_ready);
      end
      step();
    end
    el[0] = 8'h3C;
    exp_q.push_back(model(32'h0000_0100, el));
    accept_mask(32'h0000_0100, "idle");
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || elem_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_fill: got out_valid %b elem_ready %b required 0 1", out_valid, elem_ready);
    end
    step();
    elem_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== e.data || out_mask !== e.mask) begin
      errors++;
      $display("FAIL idle_data: got %b %h/%h required 1 %h/%h",
               out_valid, out_data, out_mask, e.data, e.mask);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_elem_in_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mask_expander.md
MASK_EXPANDER -- requirements
Module: mask_expander

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the width of one lane element.
REQ-002 SHALL have parameter LANES, default 32, giving the lane count; only 32 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port mask_valid, input, 1 bit: the mask_data word is valid.
REQ-006 SHALL have port mask_ready, output, 1 bit: the block accepts a mask.
REQ-007 SHALL have port mask_data, input, 32 bits: a lane-occupancy mask; bit i set means lane i receives one element.
REQ-008 SHALL have port elem_valid, input, 1 bit: a compacted element is present.
REQ-009 SHALL have port elem_ready, output, 1 bit: the block accepts an element.
REQ-010 SHALL have port elem_data, input, DATA_WIDTH bits: a compacted element, delivered in ascending lane order.
REQ-011 SHALL have port out_valid, output, 1 bit: the expanded vector is complete.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream accepts the vector.
REQ-013 SHALL have port out_data, output, 32*DATA_WIDTH bits: the expanded vector; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port out_mask, output, 32 bits: a copy of the mask for the vector on out_data.

Function
REQ-015 SHALL implement an FSM with three states: IDLE, FILL and OUT.
REQ-016 SHALL drive the handshake outputs from state only:
- mask_ready is 1 only in IDLE.
- elem_ready is 1 only in FILL.
- out_valid is 1 only in OUT.
REQ-017 SHALL perform the following on a mask handshake in IDLE:
- clear the lane buffer to all zeros;
- latch mask_data into out_mask and into a remaining register rem;
- go to FILL if mask_data is nonzero, otherwise go to OUT.
REQ-018 SHALL perform the following on each element handshake in FILL:
- write elem_data to lane p, where p is the index of the lowest set bit of rem;
- clear bit p of rem;
- go to OUT if the cleared bit was the last set bit of rem.
REQ-019 SHALL hold each lane with mask bit 0 at zero.
REQ-020 SHALL, in FILL, leave the buffer and rem unchanged in any cycle without an element handshake (stall).
REQ-021 SHALL, on out_valid && out_ready in OUT, go to IDLE; a new mask cannot be accepted in that same cycle, so the throughput floor is popcount+2 cycles per vector.
REQ-022 SHALL hold out_data and out_mask stable while out_valid=1 and out_ready=0.
REQ-023 SHALL meet these latencies:
- a mask with k set bits, with elements presented every cycle, gives out_valid k+1 cycles after mask acceptance;
- k=0 gives out_valid 1 cycle after mask acceptance.
REQ-024 SHALL ignore elem_valid outside FILL (element not consumed) and ignore mask_valid outside IDLE.

Reset
REQ-025 SHALL, while reset_n=0 (asynchronously), force:
- state to IDLE;
- buffer, out_mask and rem to 0;
- therefore mask_ready=1, elem_ready=0, out_valid=0 and out_data=0.
REQ-026 SHALL discard any partial vector when reset asserts mid-FILL or mid-OUT, and SHALL emit no out_valid for that vector after release.

Configuration
REQ-027 SHALL, when macro MASK_EXPANDER_COUNT_EN is defined:
- add output port out_count, 6 bits, equal to popcount(out_mask);
- register out_count at mask acceptance and reset it to 0;
- make its value range 0..32.
REQ-028 SHALL, without MASK_EXPANDER_COUNT_EN, have no out_count port and no counting logic.

Structure
REQ-029 SHALL take the following from shared package mask_expander_pkg:
- constants LANES=32 and CNT_W=6;
- the state enum {IDLE, FILL, OUT}.
REQ-030 SHALL contain exactly one sub-module, lsb_onehot32: a combinational 32-bit lowest-set-bit finder that returns a one-hot select and a 5-bit index.

Verification
REQ-031 SHALL cover: mask 0x0000_0005, elems 0xAA then 0xBB back-to-back -> out_valid 3 cycles after mask accept; lane0=0xAA, lane2=0xBB, all other lanes 0; out_mask=0x5.
REQ-032 SHALL cover: mask 0x0000_0000 -> out_valid the next cycle, out_data all zero, out_count=0 when MASK_EXPANDER_COUNT_EN is defined.
REQ-033 SHALL cover: mask 0xFFFF_FFFF, elems 0..31 with elem_valid toggling 1/0 -> lane i=i, out_valid after the 32nd element, out_count=32.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles in OUT -> out_data stable, mask_ready=0, a presented mask is not consumed; it is accepted 1 cycle after out_ready rises.
REQ-035 SHALL cover: mask 0x8000_0001, one element accepted, then reset_n pulsed low -> immediate IDLE with outputs 0; a following mask 0x2 with element 0x11 -> lane1=0x11 only.
REQ-036 SHALL cover: elem_valid=1 while in IDLE -> elem_ready=0 and the element is not consumed, and it becomes lane p once the mask is accepted.
